// File: rtl/alu_pipe_pkg.sv
// Shared constants and types for the alu_pipe execute unit.
package alu_pipe_pkg;

  // funct3 encodings, base ops
  localparam logic [2:0] F_ADD  = 3'd0;
  localparam logic [2:0] F_SLL  = 3'd1;
  localparam logic [2:0] F_SLT  = 3'd2;
  localparam logic [2:0] F_SLTU = 3'd3;
  localparam logic [2:0] F_XOR  = 3'd4;
  localparam logic [2:0] F_SR   = 3'd5;
  localparam logic [2:0] F_OR   = 3'd6;
  localparam logic [2:0] F_AND  = 3'd7;

  // funct3 encodings, M-extension ops
  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: XLEN iterations then one fix-up
// cycle during which done is high and result is valid.
module alu_muldiv_iter
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  logic            run, fix, b_zero, neg_q, neg_r;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi, lo, mc, a_q;
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   add_s, r_sh, sub_s;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0] q_f, r_f;

  // Operand signs only matter for the signed flavours.
  assign sa    = a[XLEN-1] && (op inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM});
  assign sb    = b[XLEN-1] && (op inside {F_MUL, F_MULH, F_DIV, F_REM});
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // hi:lo is the product accumulator for MUL*, remainder:quotient for DIV*.
  assign add_s = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
  assign r_sh  = {hi, lo[XLEN-1]};
  assign sub_s = r_sh - {1'b0, mc};

  assign prod   = {hi, lo};
  assign prod_f = neg_q ? -prod : prod;
  assign q_f    = neg_q ? -lo : lo;
  assign r_f    = neg_r ? -hi : hi;
  assign done   = fix;

  always_comb begin
    result = '0;
    case (op_q)
      F_MUL:                     result = prod_f[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: result = prod_f[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             result = b_zero ? '1 : q_f;
      default:                   result = b_zero ? a_q : r_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run <= 1'b0; fix <= 1'b0; cnt <= '0; op_q <= '0;
      hi <= '0; lo <= '0; mc <= '0; a_q <= '0;
      b_zero <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else if (start) begin
      run <= 1'b1; fix <= 1'b0; cnt <= '0; op_q <= op;
      a_q <= a; b_zero <= (b == '0);
      neg_q <= sa ^ sb; neg_r <= sa;
      hi <= '0;
      if (op[2]) begin lo <= mag_a; mc <= mag_b; end
      else       begin lo <= mag_b; mc <= mag_a; end
    end else if (run) begin
      if (op_q[2]) begin
        // restoring divide: keep the difference when it did not borrow
        if (!sub_s[XLEN]) begin hi <= sub_s[XLEN-1:0]; lo <= {lo[XLEN-2:0], 1'b1}; end
        else              begin hi <= r_sh[XLEN-1:0];  lo <= {lo[XLEN-2:0], 1'b0}; end
      end else begin
        hi <= add_s[XLEN:1];
        lo <= {add_s[0], lo[XLEN-1:1]};
      end
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN - 1)) begin run <= 1'b0; fix <= 1'b1; end
    end else begin
      fix <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered RV32I/M execute unit with valid/ready handshakes.
// Build option: ALU_PIPE_MULDIV_EN enables the iterative M-extension engine.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [2:0]       in_func,
  input  logic             in_alt,
  input  logic             in_m,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam int SW = log2(XLEN);

  state_t                 state;
  logic                   accept;
  logic [SW-1:0]          shamt;
  logic signed [XLEN-1:0] sra_v;
  logic [XLEN-1:0]        base_res;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = in_b[SW-1:0];
  assign sra_v    = $signed(in_a) >>> shamt;

  always_comb begin
    base_res = '0;
    case (in_func)
      F_ADD:  base_res = in_alt ? in_b : in_a + in_b;
      F_SLL:  base_res = in_a << shamt;
      F_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      F_SLTU: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
      F_XOR:  base_res = in_a ^ in_b;
      F_SR:   base_res = in_alt ? sra_v : in_a >> shamt;
      F_OR:   base_res = in_a | in_b;
      default: base_res = in_a & in_b;
    endcase
  end

`ifdef ALU_PIPE_MULDIV_EN
  logic            md_done;
  logic [XLEN-1:0] md_res;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && in_m),
    .op     (in_func),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_res)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE; out_valid <= 1'b0; out_result <= '0;
      out_tag <= '0; out_illegal <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
`ifdef ALU_PIPE_MULDIV_EN
          if (md_done) begin
            state <= DONE; out_valid <= 1'b1; out_result <= md_res;
          end
`endif
        end
        default: begin
          if (accept) begin
            out_tag <= in_tag;
            if (in_m) begin
`ifdef ALU_PIPE_MULDIV_EN
              state <= BUSY; out_valid <= 1'b0; out_illegal <= 1'b0;
`else
              // no engine in this build: flag the op and retire it at once
              state <= DONE; out_valid <= 1'b1; out_result <= '0; out_illegal <= 1'b1;
`endif
            end else begin
              state <= DONE; out_valid <= 1'b1; out_result <= base_res; out_illegal <= 1'b0;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE; out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a reference model and scoreboard queue.
module tb_alu_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef ALU_PIPE_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_alt, in_m;
  logic [XLEN-1:0]  in_a, in_b;
  logic [2:0]       in_func;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_illegal;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_func(in_func), .in_alt(in_alt), .in_m(in_m),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q[$];

  function automatic logic [31:0] model(input logic [2:0] f, input logic alt, input logic m,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa64, sb64, ub64;
    logic [63:0] p;
    logic signed [31:0] as;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    ub64 = longint'({32'b0, b});
    as   = a;
    if (m && !MD_EN) return 32'h0;
    if (!m) begin
      case (f)
        3'd0: return alt ? b : a + b;
        3'd1: return a << b[4:0];
        3'd2: return (sa64 < sb64) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return alt ? 32'(as >>> b[4:0]) : a >> b[4:0];
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (f)
      3'd0: begin p = 64'(sa64 * sb64); return p[31:0]; end
      3'd1: begin p = 64'(sa64 * sb64); return p[63:32]; end
      3'd2: begin p = 64'(sa64 * ub64); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa64 / sb64);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : 32'(sa64 % sb64);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Presents one op, waits for acceptance, queues the model's expectation.
  task automatic issue(input string nm, input logic [2:0] f, input logic alt, input logic m,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] lit, input bit keep, output int acc);
    exp_t e;
    int n;
    in_func = f; in_alt = alt; in_m = m; in_a = a; in_b = b; in_tag = tag;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout %s: in_ready stayed 0, required 1", nm);
      in_valid = 1'b0; acc = -1;
      return;
    end
    @(posedge clk); #1;
    acc   = cyc;
    e.res = model(f, alt, m, a, b);
    e.tag = tag;
    e.ill = m && !MD_EN;
    e.acc = acc;
    e.lat = (m && MD_EN) ? XLEN + 2 : 1;
    q.push_back(e);
    chk({"model_", nm}, e.res, lit);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: latency on first appearance, hold while stalled, value on handoff.
  bit          fresh = 1'b1;
  logic [31:0] hr;
  logic [4:0]  ht;
  logic        hil;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL spurious_valid: out_valid=1 with result %h, required no output", out_result);
      end else begin
        if (fresh) chk("latency", 32'(cyc - q[0].acc + 1), 32'(q[0].lat));
        else begin
          chk("hold_result", out_result, hr);
          chk("hold_tag", 32'(out_tag), 32'(ht));
          chk("hold_illegal", 32'(out_illegal), 32'(hil));
        end
        if (out_ready) begin
          chk("result", out_result, q[0].res);
          chk("tag", 32'(out_tag), 32'(q[0].tag));
          chk("illegal", 32'(out_illegal), 32'(q[0].ill));
          void'(q.pop_front());
          fresh = 1'b1;
        end else begin
          fresh = 1'b0; hr = out_result; ht = out_tag; hil = out_illegal;
        end
      end
    end else begin
      fresh = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, a3, k, bad;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_func = '0; in_alt = 1'b0; in_m = 1'b0; in_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    issue("add_wrap", 3'd0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 5'd5, 32'h8000_0000, 1'b0, a0);
    wait_drain();

    // back-to-back with in_valid held
    issue("add", 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 5'd1, 32'd3, 1'b1, a0);
    issue("xor", 3'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_00FF, 5'd2, 32'h0000_F00F, 1'b1, a1);
    issue("or", 3'd6, 1'b0, 1'b0, 32'h0000_0F00, 32'h0000_00F0, 5'd3, 32'h0000_0FF0, 1'b1, a2);
    issue("and", 3'd7, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd4, 32'h0F00_0F00, 1'b0, a3);
    chk("b2b_cycles", 32'(a3 - a0), 32'd3);
    wait_drain();

    issue("lui", 3'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5000, 5'd6, 32'h1234_5000, 1'b1, a0);
    issue("sll", 3'd1, 1'b0, 1'b0, 32'h1, 32'h24, 5'd7, 32'h10, 1'b1, a0);
    issue("sra", 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'h21, 5'd8, 32'hC000_0000, 1'b1, a0);
    issue("srl", 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h21, 5'd9, 32'h4000_0000, 1'b1, a0);
    issue("slt", 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd10, 32'd1, 1'b1, a0);
    issue("sltu", 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd11, 32'd0, 1'b0, a0);
    wait_drain();

`ifdef ALU_PIPE_MULDIV_EN
    issue("mulh", 3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 1'b0, a0);
    bad = 0;
    for (int i = 0; i < XLEN + 1; i++) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    chk("busy_in_ready", 32'(bad), 32'd0);
    wait_drain();
`else
    issue("mul_illegal", 3'd0, 1'b0, 1'b1, 32'h3, 32'h5, 5'd12, 32'h0, 1'b0, a0);
    wait_drain();
`endif
    issue("mul", 3'd0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h0, 1'b0, a0);
    issue("mulhu", 3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14,
          MD_EN ? 32'hFFFF_FFFE : 32'h0, 1'b0, a0);
    issue("mulhsu", 3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15,
          MD_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0, a0);
    issue("div_by0", 3'd4, 1'b0, 1'b1, 32'd7, 32'd0, 5'd16, MD_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0, a0);
    issue("rem_by0", 3'd6, 1'b0, 1'b1, 32'd7, 32'd0, 5'd17, MD_EN ? 32'd7 : 32'h0, 1'b0, a0);
    issue("div_ovf", 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18,
          MD_EN ? 32'h8000_0000 : 32'h0, 1'b0, a0);
    issue("rem_ovf", 3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0, 1'b0, a0);
    issue("div_neg", 3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd20, MD_EN ? 32'hFFFF_FFFD : 32'h0, 1'b0, a0);
    issue("rem_neg", 3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd21, MD_EN ? 32'hFFFF_FFFF : 32'h0, 1'b0, a0);
    issue("divu", 3'd5, 1'b0, 1'b1, 32'd100, 32'd7, 5'd22, MD_EN ? 32'd14 : 32'h0, 1'b0, a0);
    issue("remu", 3'd7, 1'b0, 1'b1, 32'd100, 32'd7, 5'd23, MD_EN ? 32'd2 : 32'h0, 1'b0, a0);
    wait_drain();

    // backpressure, then release together with a new op
    @(negedge clk);
    out_ready = 1'b0;
    issue("bp_xor", 3'd4, 1'b0, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 5'd24, 32'h5555_5555, 1'b0, a0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) bad++;
    end
    chk("bp_in_ready", 32'(bad), 32'd0);
    out_ready = 1'b1;
    k = cyc;
    issue("bp_or", 3'd6, 1'b0, 1'b0, 32'h1, 32'h2, 5'd25, 32'h3, 1'b0, a1);
    chk("bp_same_cycle_accept", 32'(a1 - k), 32'd1);
    wait_drain();

    // reset while an op is in flight
    @(negedge clk);
`ifdef ALU_PIPE_MULDIV_EN
    issue("div_abort", 3'd4, 1'b0, 1'b1, 32'd100, 32'd7, 5'd26, 32'd14, 1'b0, a0);
    repeat (9) @(negedge clk);
`else
    out_ready = 1'b0;
    issue("add_abort", 3'd0, 1'b0, 1'b0, 32'd10, 32'd20, 5'd26, 32'd30, 1'b0, a0);
    repeat (3) @(negedge clk);
`endif
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", out_result, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    issue("add_after_rst", 3'd0, 1'b0, 1'b0, 32'd40, 32'd2, 5'd27, 32'd42, 1'b0, a0);
    issue("divu_after_rst", 3'd5, 1'b0, 1'b1, 32'd99, 32'd10, 5'd28, MD_EN ? 32'd9 : 32'h0, 1'b0, a0);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
